// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline types and widths used by the hazard unit and its peers
package hazard_unit_pkg;

    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int STALL_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } hazard_state_t;

    function automatic logic src_match(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= '0;
        else if (inc && !(&value)) value <= value + 1'b1;
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control for load-use, memory waits and branch redirects
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_AW-1:0]      rs1_addr_D,
    input  logic [REG_AW-1:0]      rs2_addr_D,
    input  logic                   rs1_used_D,
    input  logic                   rs2_used_D,
    input  logic [REG_AW-1:0]      rd_addr_E,
    input  logic                   mem_read_E,
    input  logic                   branch_taken_E,
    input  logic                   dmem_req_M,
    input  logic                   dmem_ack_M,
    output logic                   stall_F,
    output logic                   stall_D,
    output logic                   stall_E,
    output logic                   stall_M,
    output logic                   flush_D,
    output logic                   flush_E,
    output logic                   bubble_W,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    hazard_state_t state, next_state;
    logic flush_pending, next_flush_pending;
    logic load_use, mem_wait, redirect, redirect_flush;

    assign load_use = mem_read_E && (rd_addr_E != '0) &&
                      (src_match(rs1_used_D, rs1_addr_D, rd_addr_E) ||
                       src_match(rs2_used_D, rs2_addr_D, rd_addr_E));
    assign mem_wait = dmem_req_M && !dmem_ack_M;
    // a pending flush can only exist while the wait that deferred it is in progress
    assign redirect = branch_taken_E || (flush_pending && state == MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            flush_pending <= 1'b0;
        end else begin
            state         <= next_state;
            flush_pending <= next_flush_pending;
        end
    end

    always_comb begin
        next_state         = mem_wait ? MEM_WAIT : RUN;
        next_flush_pending = mem_wait && (flush_pending || branch_taken_E);
        stall_F            = 1'b0;
        stall_D            = 1'b0;
        stall_E            = 1'b0;
        stall_M            = 1'b0;
        flush_D            = 1'b0;
        flush_E            = 1'b0;
        bubble_W           = 1'b0;
        redirect_flush     = 1'b0;
        if (mem_wait) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            bubble_W = 1'b1;
        end else if (redirect) begin
            flush_D        = 1'b1;
            flush_E        = 1'b1;
            redirect_flush = 1'b1;
        end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_F),
        .value (stall_cycles)
    );

    sat_counter #(.WIDTH(FLUSH_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_flush),
        .value (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a behavioural model
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rd_addr_E;
    logic        rs1_used_D, rs2_used_D, mem_read_E, branch_taken_E, dmem_req_M, dmem_ack_M;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int checks = 0;
    int failures = 0;

    bit      m_pend = 1'b0;
    longint  m_sc = 0;
    int      m_fc = 0;

    hazard_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_addr_D     (rs1_addr_D),
        .rs2_addr_D     (rs2_addr_D),
        .rs1_used_D     (rs1_used_D),
        .rs2_used_D     (rs2_used_D),
        .rd_addr_E      (rd_addr_E),
        .mem_read_E     (mem_read_E),
        .branch_taken_E (branch_taken_E),
        .dmem_req_M     (dmem_req_M),
        .dmem_ack_M     (dmem_ack_M),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .stall_E        (stall_E),
        .stall_M        (stall_M),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .bubble_W       (bubble_W),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    wire [6:0] ctrl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs decided by which hazard wins this cycle, counters as plain integers
    always @(negedge clk) begin
        bit mw, lu, redir;
        logic [6:0] exp;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_sc = 0;
            m_fc = 0;
        end
        mw = dmem_req_M && !dmem_ack_M;
        lu = mem_read_E && rd_addr_E != 0 &&
             ((rs1_used_D && rs1_addr_D == rd_addr_E) || (rs2_used_D && rs2_addr_D == rd_addr_E));
        redir = branch_taken_E || m_pend;
        if (mw) exp = 7'b1111001;
        else if (redir) exp = 7'b0000110;
        else if (lu) exp = 7'b1100010;
        else exp = 7'b0000000;
        check("model_ctrl", {25'd0, ctrl}, {25'd0, exp});
        check("model_stall_cycles", stall_cycles, m_sc[31:0]);
        check("model_flush_count", {16'd0, flush_count}, m_fc);
        if (rst_n) begin
            if (exp[6] && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (!mw && redir && m_fc < 16'hFFFF) m_fc++;
            m_pend = mw && (m_pend || branch_taken_E);
        end
    end

    task automatic clear_inputs();
        rs1_addr_D = 0; rs2_addr_D = 0; rd_addr_E = 0;
        rs1_used_D = 0; rs2_used_D = 0; mem_read_E = 0;
        branch_taken_E = 0; dmem_req_M = 0; dmem_ack_M = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_ctrl", {25'd0, ctrl}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_flush_count", {16'd0, flush_count}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        // load-use on rs2
        next_cycle();
        mem_read_E = 1; rd_addr_E = 5; rs2_used_D = 1; rs2_addr_D = 5;
        @(negedge clk);
        check("load_use_ctrl", {25'd0, ctrl}, 32'b1100010);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("load_use_stall_cycles", stall_cycles, 32'd1);
        check("load_use_released", {25'd0, ctrl}, 32'd0);
        // load to x0 never stalls
        next_cycle();
        mem_read_E = 1; rd_addr_E = 0; rs2_used_D = 1; rs2_addr_D = 0;
        @(negedge clk);
        check("load_x0_ctrl", {25'd0, ctrl}, 32'd0);
        // branch beats load-use
        next_cycle();
        mem_read_E = 1; rd_addr_E = 5; rs2_used_D = 1; rs2_addr_D = 5; branch_taken_E = 1;
        @(negedge clk);
        check("branch_lu_ctrl", {25'd0, ctrl}, 32'b0000110);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("branch_flush_count", {16'd0, flush_count}, 32'd1);
        check("branch_stall_cycles", stall_cycles, 32'd1);
        // three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dmem_req_M = 1; dmem_ack_M = 0;
            @(negedge clk);
            check("mem_wait_ctrl", {25'd0, ctrl}, 32'b1111001);
        end
        next_cycle();
        dmem_ack_M = 1;
        @(negedge clk);
        check("mem_ack_ctrl", {25'd0, ctrl}, 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("mem_wait_stall_cycles", stall_cycles, 32'd4);
        // branch deferred by a wait, issued on the ack cycle
        next_cycle();
        dmem_req_M = 1; branch_taken_E = 1;
        @(negedge clk);
        check("defer_wait1_ctrl", {25'd0, ctrl}, 32'b1111001);
        next_cycle();
        branch_taken_E = 0;
        @(negedge clk);
        check("defer_wait2_ctrl", {25'd0, ctrl}, 32'b1111001);
        next_cycle();
        dmem_ack_M = 1;
        @(negedge clk);
        check("defer_ack_ctrl", {25'd0, ctrl}, 32'b0000110);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("defer_flush_count", {16'd0, flush_count}, 32'd2);
        check("defer_no_repeat", {25'd0, ctrl}, 32'd0);
        // reset during a wait with a pending flush
        next_cycle();
        dmem_req_M = 1; branch_taken_E = 1;
        next_cycle();
        branch_taken_E = 0;
        next_cycle();
        rst_n = 0; dmem_req_M = 0;
        @(negedge clk);
        check("rst_mid_stall_cycles", stall_cycles, 32'd0);
        check("rst_mid_flush_count", {16'd0, flush_count}, 32'd0);
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        check("rst_mid_no_flush", {25'd0, ctrl}, 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst_n = ($urandom_range(0, 199) != 0);
            rs1_addr_D = 5'($urandom_range(0, 3));
            rs2_addr_D = 5'($urandom_range(0, 3));
            rd_addr_E = 5'($urandom_range(0, 3));
            rs1_used_D = 1'($urandom);
            rs2_used_D = 1'($urandom);
            mem_read_E = 1'($urandom);
            branch_taken_E = ($urandom_range(0, 5) == 0);
            dmem_req_M = ($urandom_range(0, 2) != 0);
            dmem_ack_M = 1'($urandom);
        end
        // saturate the flush counter
        next_cycle();
        rst_n = 0;
        clear_inputs();
        next_cycle();
        rst_n = 1;
        branch_taken_E = 1;
        repeat (65538) next_cycle();
        @(negedge clk);
        check("flush_count_saturated", {16'd0, flush_count}, 32'h0000_FFFF);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
